hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 3-stage core (Fetch / Execute / Memory-Writeback).
//  Generates per-operand forwarding selects for N source operands.
//  Runs a state machine for multi-cycle load-use stalls, multi-cycle execute ops (MUL/DIV)
//  with a timeout, and multi-cycle branch flushes. Keeps a saturating stall-cycle counter.
// PARAMETERS
//  NUM_SRC        2   source operands per EX instruction (3 for fused/R4 ops)
//  REG_ADDR_WIDTH 5   register address width; address 0 is hard-wired zero
//  LOAD_LATENCY   1   stall cycles per load-use hazard (>=1)
//  FLUSH_CYCLES   1   cycles flush_fetch is held per taken branch (>=1)
//  MC_TIMEOUT     64  max cycles waiting for mc_done; 0 disables the timeout
//  CNT_WIDTH      16  width of stall_cycle_count
// PORTS
//  clk                in  1                     core clock
//  rst_n              in  1                     asynchronous active-low reset
//  ex_valid           in  1                     EX holds a real (non-bubble) instruction
//  ex_src_addr        in  NUM_SRC*REG_ADDR_WIDTH  source i at [i*W +: W]
//  ex_src_used        in  NUM_SRC               source i is read by the EX instruction
//  ex_mc_start        in  1                     EX instruction is a multi-cycle op
//  mc_done            in  1                     multi-cycle unit result valid (1-cycle pulse)
//  mw_valid           in  1                     MW holds a real instruction
//  mw_write_enable    in  1                     MW instruction writes the register file
//  mw_write_address   in  REG_ADDR_WIDTH        MW destination register
//  mw_is_load         in  1                     MW instruction is a load
//  pc_source          in  1                     EX branch/jump taken
//  forward_sel        out NUM_SRC               1 = operand i takes the MW result
//  stall_fetch        out 1                     hold PC and the F/EX register
//  stall_execute      out 1                     hold the EX instruction
//  hold_memory_write  out 1                     hold MW contents (the load in progress)
//  bubble_memory_write out 1                    insert a bubble into MW next cycle
//  flush_fetch        out 1                     squash the instruction entering EX
//  mc_timeout         out 1                     1-cycle pulse: multi-cycle op timed out
//  stall_cycle_count  out CNT_WIDTH             saturating count of stall_execute cycles
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all counters 0.
//   - Every output is 0 while rst_n=0, including mid-stall or mid-flush.
//  match[i] = ex_valid & mw_valid & mw_write_enable & ex_src_used[i]
//             & (src_i == mw_write_address) & (src_i != 0)
//  load_haz = mw_is_load & |match
//  forward_sel[i] = match[i] & (~mw_is_load | state==LOAD_RELEASE)
//   - Combinational in every state except FLUSH, where it is 0.
//  States:
//   IDLE, checked in priority order:
//    1. load_haz:
//       - stall_fetch=stall_execute=hold_memory_write=1.
//       - Next state is LOAD_WAIT with cnt=LOAD_LATENCY-1, or LOAD_RELEASE if LOAD_LATENCY=1.
//    2. ex_valid & ex_mc_start:
//       - stall_fetch=stall_execute=bubble_memory_write=1.
//       - Next state is MC_BUSY, timer=1.
//       - If mc_done is already 1 this cycle: no stall; remain in IDLE.
//    3. pc_source:
//       - flush_fetch=1.
//       - Next state is FLUSH with cnt=FLUSH_CYCLES-1, or IDLE if FLUSH_CYCLES=1.
//   LOAD_WAIT:
//    - Same stall outputs as IDLE case 1; cnt decrements.
//    - At cnt==1, go to LOAD_RELEASE.
//   LOAD_RELEASE:
//    - No stall; load hazard is suppressed; load result is forwarded.
//    - pc_source is honoured (flush as in IDLE case 3); otherwise go to IDLE.
//   MC_BUSY:
//    - stall_fetch=stall_execute=bubble_memory_write=1 until mc_done.
//    - mc_done cycle: stalls drop; pc_source is honoured; go to IDLE (or FLUSH).
//    - If MC_TIMEOUT != 0 and timer==MC_TIMEOUT without mc_done:
//      mc_timeout=1 and stalls drop that cycle; go to IDLE.
//   FLUSH:
//    - flush_fetch=1; cnt decrements; at cnt==1 go to IDLE.
//    - All hazards are ignored (EX holds a squashed instruction).
//  Rules:
//   - pc_source is ignored whenever stall_execute=1 (branch not yet resolved).
//   - Simultaneous load_haz and pc_source: the stall wins; the branch re-resolves at release.
//   - stall_cycle_count increments on every stall_execute=1 cycle and holds at all-ones.
//   - Latency: hazard outputs are combinational in the detection cycle.
//     Stall for a load-use hazard is exactly LOAD_LATENCY cycles.
// TESTING
//  - load x5 in MW, EX add x6,x5,x1, LOAD_LATENCY=2:
//    stall for cycles t, t+1; t+2 gives forward_sel=01 with no stall; stall_cycle_count=2.
//  - MW writes x0 with EX reading x0, or ex_src_used=0: forward_sel=00 and no stall.
//  - ex_mc_start, mc_done 5 cycles later:
//    stall+bubble for 5 cycles, drops in the mc_done cycle; count=5.
//  - MC_TIMEOUT=4 and mc_done never asserted: mc_timeout pulses in cycle 4; state returns to IDLE.
//  - FLUSH_CYCLES=2 with pc_source: flush_fetch=1 for 2 cycles; a matching MW write in cycle 2 is not forwarded.
//  - load_haz together with pc_source, then rst_n low mid-LOAD_WAIT:
//    no flush while stalled; on reset all outputs are 0 immediately and the next cycle is IDLE.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-controller bundle: EX/MW instruction status in, stall/flush/forward controls out.
interface hazard_control_unit_if #(
   parameter int NUM_SRC        = 2,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
);
   logic                              ex_valid;
   logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ex_src_addr;
   logic [NUM_SRC-1:0]                ex_src_used;
   logic                              ex_mc_start;
   logic                              mc_done;
   logic                              mw_valid;
   logic                              mw_write_enable;
   logic [REG_ADDR_WIDTH-1:0]         mw_write_address;
   logic                              mw_is_load;
   logic                              pc_source;

   logic [NUM_SRC-1:0]                forward_sel;
   logic                              stall_fetch;
   logic                              stall_execute;
   logic                              hold_memory_write;
   logic                              bubble_memory_write;
   logic                              flush_fetch;
   logic                              mc_timeout;
   logic [CNT_WIDTH-1:0]              stall_cycle_count;

   // Pipeline side: reports instruction status, obeys the hazard controls.
   modport master (
      output ex_valid, ex_src_addr, ex_src_used, ex_mc_start, mc_done,
             mw_valid, mw_write_enable, mw_write_address, mw_is_load, pc_source,
      input  forward_sel, stall_fetch, stall_execute, hold_memory_write,
             bubble_memory_write, flush_fetch, mc_timeout, stall_cycle_count
   );

   // Hazard controller side.
   modport slave (
      input  ex_valid, ex_src_addr, ex_src_used, ex_mc_start, mc_done,
             mw_valid, mw_write_enable, mw_write_address, mw_is_load, pc_source,
      output forward_sel, stall_fetch, stall_execute, hold_memory_write,
             bubble_memory_write, flush_fetch, mc_timeout, stall_cycle_count
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the Fetch / Execute / Memory-Writeback core: operand forwarding,
// load-use stalls, multi-cycle execute waits with timeout, branch flushes, stall statistics.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | normal flow; detects load-use, multi-cycle start, taken branch
// LOAD_WAIT    | load-use stall continues; cnt counts remaining stall cycles
// LOAD_RELEASE | stall over; the load result is forwarded, load hazard masked
// MC_BUSY      | waiting for mc_done; timer counts cycles for the timeout
// FLUSH        | squashing instructions after a taken branch; cnt counts down
module hazard_control_unit #(
   parameter int NUM_SRC        = 2,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LOAD_LATENCY   = 1,
   parameter int FLUSH_CYCLES   = 1,
   parameter int MC_TIMEOUT     = 64,
   parameter int CNT_WIDTH      = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   hazard_control_unit_if.slave   bus
);

   localparam int CNT_MAX = (LOAD_LATENCY > FLUSH_CYCLES) ? LOAD_LATENCY : FLUSH_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_LATENCY - 1);
   localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LIM  = TW'(MC_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_WAIT, S_LOAD_RELEASE, S_MC_BUSY, S_FLUSH
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;

   logic [NUM_SRC-1:0]   match;
   logic [NUM_SRC-1:0]   fwd_c;
   logic                 load_haz;
   logic                 branch_ok;
   logic                 stall_f_c, stall_e_c, hold_mw_c, bubble_mw_c, flush_c, timeout_c;

   // Hazard detection, next-state and control outputs for the current cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      branch_ok   = 1'b0;
      stall_f_c   = 1'b0;
      stall_e_c   = 1'b0;
      hold_mw_c   = 1'b0;
      bubble_mw_c = 1'b0;
      flush_c     = 1'b0;
      timeout_c   = 1'b0;
      match       = '0;

      for (int i = 0; i < NUM_SRC; i++) begin
         match[i] = bus.ex_valid & bus.mw_valid & bus.mw_write_enable & bus.ex_src_used[i]
                  & (bus.ex_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == bus.mw_write_address)
                  & (bus.ex_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
      end
      load_haz = bus.mw_is_load & (|match);

      // The squashed instruction in EX during a flush must not steer operands.
      if (state_q == S_FLUSH)
         fwd_c = '0;
      else
         fwd_c = match & {NUM_SRC{~bus.mw_is_load | (state_q == S_LOAD_RELEASE)}};

      case (state_q)
         S_IDLE, S_LOAD_RELEASE: begin
            if (state_q == S_IDLE && load_haz) begin
               stall_f_c = 1'b1;
               stall_e_c = 1'b1;
               hold_mw_c = 1'b1;
               if (LOAD_LATENCY == 1) begin
                  state_d = S_LOAD_RELEASE;
               end else begin
                  state_d = S_LOAD_WAIT;
                  cnt_d   = LOAD_INIT;
               end
            end else if (state_q == S_IDLE && bus.ex_valid && bus.ex_mc_start && !bus.mc_done) begin
               stall_f_c   = 1'b1;
               stall_e_c   = 1'b1;
               bubble_mw_c = 1'b1;
               state_d     = S_MC_BUSY;
               timer_d     = TW'(1);
            end else begin
               // A multi-cycle op already done counts as an ordinary instruction.
               state_d   = S_IDLE;
               branch_ok = 1'b1;
            end
         end
         S_LOAD_WAIT: begin
            stall_f_c = 1'b1;
            stall_e_c = 1'b1;
            hold_mw_c = 1'b1;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = S_LOAD_RELEASE;
         end
         S_MC_BUSY: begin
            if (bus.mc_done) begin
               state_d   = S_IDLE;
               branch_ok = 1'b1;
            end else if (MC_TIMEOUT != 0 && timer_q == TIMER_LIM) begin
               timeout_c = 1'b1;
               state_d   = S_IDLE;
            end else begin
               stall_f_c   = 1'b1;
               stall_e_c   = 1'b1;
               bubble_mw_c = 1'b1;
               timer_d     = timer_q + TW'(1);
            end
         end
         S_FLUSH: begin
            flush_c = 1'b1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A branch only resolves in a cycle where EX is free to advance.
      if (branch_ok && bus.pc_source) begin
         flush_c = 1'b1;
         if (FLUSH_CYCLES == 1) begin
            state_d = S_IDLE;
         end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
         end
      end
   end

   // FSM state, shared stall/flush counter and multi-cycle timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
      end
   end

   // Saturating count of cycles in which EX was held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (stall_e_c && stall_cnt_q != '1)
         stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
   end

   // Controls are combinational, so gate them to keep the pipeline quiet during reset.
   assign bus.forward_sel         = fwd_c & {NUM_SRC{rst_n}};
   assign bus.stall_fetch         = stall_f_c & rst_n;
   assign bus.stall_execute       = stall_e_c & rst_n;
   assign bus.hold_memory_write   = hold_mw_c & rst_n;
   assign bus.bubble_memory_write = bubble_mw_c & rst_n;
   assign bus.flush_fetch         = flush_c & rst_n;
   assign bus.mc_timeout          = timeout_c & rst_n;
   assign bus.stall_cycle_count   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios then random traffic,
// expected outputs from a behavioural model, compared by an independent monitor.
module tb_hazard_control_unit;

   localparam int NS = 2;
   localparam int AW = 5;
   localparam int LL = 2;
   localparam int FC = 2;
   localparam int TO = 6;
   localparam int CW = 6;
   localparam int CNT_SAT = (1 << CW) - 1;

   typedef struct packed {
      logic             rst_n;
      logic             ex_valid;
      logic [NS*AW-1:0] src;
      logic [NS-1:0]    used;
      logic             mc_start;
      logic             mc_done;
      logic             mw_valid;
      logic             mw_we;
      logic [AW-1:0]    mw_addr;
      logic             mw_is_load;
      logic             pc;
   } stim_t;

   typedef struct packed {
      logic [NS-1:0] fwd;
      logic          sf;
      logic          se;
      logic          hm;
      logic          bm;
      logic          ff;
      logic          to;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_control_unit_if #(.NUM_SRC(NS), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hif();

   hazard_control_unit #(
      .NUM_SRC(NS), .REG_ADDR_WIDTH(AW), .LOAD_LATENCY(LL),
      .FLUSH_CYCLES(FC), .MC_TIMEOUT(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hif)
   );

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Reference model: pipeline situation plus remaining-cycle budgets.
   localparam int M_NORM = 0, M_LOAD = 1, M_REL = 2, M_MC = 3, M_FL = 4;
   int mode = M_NORM;
   int left = 0;
   int age = 0;
   int stall_cnt = 0;

   task automatic drive_and_predict(input stim_t s);
      exp_t          e;
      logic [NS-1:0] m;
      logic [AW-1:0] a;
      bit            branch_ok;
      rst_n                = s.rst_n;
      hif.ex_valid         = s.ex_valid;
      hif.ex_src_addr      = s.src;
      hif.ex_src_used      = s.used;
      hif.ex_mc_start      = s.mc_start;
      hif.mc_done          = s.mc_done;
      hif.mw_valid         = s.mw_valid;
      hif.mw_write_enable  = s.mw_we;
      hif.mw_write_address = s.mw_addr;
      hif.mw_is_load       = s.mw_is_load;
      hif.pc_source        = s.pc;
      e = '0;
      if (!s.rst_n) begin
         mode = M_NORM; left = 0; age = 0; stall_cnt = 0;
      end else begin
         for (int i = 0; i < NS; i++) begin
            a    = s.src[i*AW +: AW];
            m[i] = s.ex_valid && s.mw_valid && s.mw_we && s.used[i] && a == s.mw_addr && a != 0;
         end
         branch_ok = 0;
         if (mode == M_FL)       e.fwd = '0;
         else if (mode == M_REL) e.fwd = m;
         else                    e.fwd = s.mw_is_load ? '0 : m;
         if (mode == M_NORM && s.mw_is_load && m != 0) begin
            e.sf = 1; e.se = 1; e.hm = 1;
            left = LL - 1;
            mode = (left > 0) ? M_LOAD : M_REL;
         end else if (mode == M_NORM && s.ex_valid && s.mc_start && !s.mc_done) begin
            e.sf = 1; e.se = 1; e.bm = 1;
            age = 1; mode = M_MC;
         end else if (mode == M_NORM || mode == M_REL) begin
            mode = M_NORM; branch_ok = 1;
         end else if (mode == M_LOAD) begin
            e.sf = 1; e.se = 1; e.hm = 1;
            left--;
            if (left == 0) mode = M_REL;
         end else if (mode == M_MC) begin
            if (s.mc_done) begin
               mode = M_NORM; branch_ok = 1;
            end else if (age == TO) begin
               e.to = 1; mode = M_NORM;
            end else begin
               e.sf = 1; e.se = 1; e.bm = 1; age++;
            end
         end else begin
            e.ff = 1; left--;
            if (left == 0) mode = M_NORM;
         end
         if (branch_ok && s.pc) begin
            e.ff = 1;
            left = FC - 1;
            mode = (left > 0) ? M_FL : M_NORM;
         end
         e.cnt = CW'(stall_cnt);
         if (e.se && stall_cnt < CNT_SAT) stall_cnt++;
      end
      sb_q.push_back(e);
   endtask

   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      drive_and_predict(s);
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = quiet();
      s.rst_n      = ($urandom_range(0, 249) != 0);
      s.ex_valid   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++) s.src[i*AW +: AW] = AW'($urandom_range(0, 3));
      s.used       = NS'($urandom);
      s.mc_start   = ($urandom_range(0, 7) == 0);
      s.mc_done    = ($urandom_range(0, 5) == 0);
      s.mw_valid   = ($urandom_range(0, 3) != 0);
      s.mw_we      = ($urandom_range(0, 3) != 0);
      s.mw_addr    = AW'($urandom_range(0, 3));
      s.mw_is_load = $urandom_range(0, 1) == 1;
      // A multi-cycle op is never itself a branch.
      s.pc         = !s.mc_start && ($urandom_range(0, 4) == 0);
      return s;
   endfunction

   // Monitor: every cycle the DUT presents its controls; compare with the oldest prediction.
   initial begin
      exp_t e, act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act.fwd = hif.forward_sel;
            act.sf  = hif.stall_fetch;
            act.se  = hif.stall_execute;
            act.hm  = hif.hold_memory_write;
            act.bm  = hif.bubble_memory_write;
            act.ff  = hif.flush_fetch;
            act.to  = hif.mc_timeout;
            act.cnt = hif.stall_cycle_count;
            tests++;
            if (act !== e) begin
               fails++;
               $display("FAIL cycle %0d outputs: got fwd=%b sf=%b se=%b hm=%b bm=%b ff=%b to=%b cnt=%0d, expected fwd=%b sf=%b se=%b hm=%b bm=%b ff=%b to=%b cnt=%0d",
                        cyc, act.fwd, act.sf, act.se, act.hm, act.bm, act.ff, act.to, act.cnt,
                        e.fwd, e.sf, e.se, e.hm, e.bm, e.ff, e.to, e.cnt);
            end
            cyc++;
         end
      end
   end

   // Stimulus: directed scenarios first, then random traffic with occasional resets.
   initial begin
      stim_t s;
      hif.ex_valid = 0; hif.ex_src_addr = '0; hif.ex_src_used = '0; hif.ex_mc_start = 0;
      hif.mc_done = 0; hif.mw_valid = 0; hif.mw_write_enable = 0; hif.mw_write_address = '0;
      hif.mw_is_load = 0; hif.pc_source = 0;

      s = quiet(); s.rst_n = 0;
      step(s); step(s);
      step(quiet());

      // load x5 in MW, EX add x6,x5,x1: two stall cycles then forward operand 0.
      s = quiet();
      s.ex_valid = 1; s.src = {AW'(1), AW'(5)}; s.used = 2'b11;
      s.mw_valid = 1; s.mw_we = 1; s.mw_addr = 5; s.mw_is_load = 1;
      for (int i = 0; i < 3; i++) step(s);
      step(quiet());

      // Write to x0 with EX reading x0, and a match on an unused operand.
      s = quiet();
      s.ex_valid = 1; s.src = {AW'(0), AW'(0)}; s.used = 2'b11;
      s.mw_valid = 1; s.mw_we = 1; s.mw_addr = 0;
      step(s);
      s.src = {AW'(7), AW'(7)}; s.used = 2'b00; s.mw_addr = 7;
      step(s);
      s.used = 2'b10;
      step(s);

      // Multi-cycle op finishing five cycles after its start.
      s = quiet(); s.ex_valid = 1; s.mc_start = 1;
      step(s);
      for (int i = 0; i < 4; i++) step(s);
      s.mc_done = 1;
      step(s);
      step(quiet());

      // Multi-cycle op that never finishes: timeout.
      s = quiet(); s.ex_valid = 1; s.mc_start = 1;
      for (int i = 0; i < TO + 2; i++) step(s);
      step(quiet());

      // Taken branch, then a matching MW write during the second flush cycle.
      s = quiet(); s.pc = 1;
      step(s);
      s = quiet();
      s.ex_valid = 1; s.src = {AW'(2), AW'(3)}; s.used = 2'b11;
      s.mw_valid = 1; s.mw_we = 1; s.mw_addr = 3;
      step(s);
      step(s);

      // Load hazard with a taken branch, then reset during the stall.
      s = quiet();
      s.ex_valid = 1; s.src = {AW'(1), AW'(4)}; s.used = 2'b01;
      s.mw_valid = 1; s.mw_we = 1; s.mw_addr = 4; s.mw_is_load = 1; s.pc = 1;
      step(s);
      s.rst_n = 0;
      step(s);
      s.rst_n = 1;
      step(s);
      step(s);
      step(s);

      for (int i = 0; i < 3000; i++) step(rand_stim());

      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard drain: %0d predictions left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
